// File: rtl/vga_pkg.sv
// Shared VGA scene definitions: scene indices, default pixel geometry and
// the scene-transition state encoding.
package vga_pkg;

    localparam int SMENU = 0;
    localparam int SGAME = 1;
    localparam int SOVER = 2;

    localparam int VGA_PIXEL_W = 12;
    localparam int VGA_CH_W    = VGA_PIXEL_W / 3;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_e;

endpackage

// File: rtl/pixel_dimmer.sv
// Combinational brightness scaler: each RGB channel becomes
// (channel * level) >> FADE_SHIFT, so level = 2^FADE_SHIFT passes through.
module pixel_dimmer
    import vga_pkg::*;
#(
    parameter int PIXEL_W    = 12,
    parameter int FADE_SHIFT = 3
) (
    input  logic [PIXEL_W-1:0]  pixel_in,
    input  logic [FADE_SHIFT:0] level,
    output logic [PIXEL_W-1:0]  pixel_out
);

    localparam int CH_W   = PIXEL_W / 3;
    localparam int PROD_W = CH_W + FADE_SHIFT + 1;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [PROD_W-1:0] prod;
        assign prod = PROD_W'(pixel_in[c*CH_W +: CH_W]) * PROD_W'(level);
        assign pixel_out[c*CH_W +: CH_W] = CH_W'(prod >> FADE_SHIFT);
    end

    if (PIXEL_W % 3 != 0) begin : g_pad
        assign pixel_out[PIXEL_W-1:3*CH_W] = '0;
    end

endmodule

// File: rtl/scene_pixel_mux.sv
// Frame-synchronous scene selector for the VGA pixel bus with optional
// fade-to-black / fade-in between scenes and a registered output.
//
// state    | meaning
// SHOW     | full brightness, current scene displayed
// FADE_OUT | level stepping down one per frame toward black
// FADE_IN  | new scene, level stepping up one per frame toward full
module scene_pixel_mux
    import vga_pkg::*;
#(
    parameter int                 NUM_SCENES  = 4,
    parameter int                 SEL_W       = 2,
    parameter int                 PIXEL_W     = 12,
    parameter bit                 FADE_EN     = 1'b1,
    parameter int                 FADE_SHIFT  = 3,
    parameter logic [PIXEL_W-1:0] BG_COLOR    = '0,
    parameter int                 RESET_SCENE = 0
) (
    input  logic                          clka,
    input  logic                          rst,
    input  logic [9:0]                    h_cnt,
    input  logic [9:0]                    v_cnt,
    input  logic                          valid,
    input  logic [SEL_W-1:0]              scene_sel,
    input  logic [NUM_SCENES*PIXEL_W-1:0] scene_pixels,
    output logic [PIXEL_W-1:0]            pixel_out,
    output logic [SEL_W-1:0]              cur_scene,
    output logic                          fading
);

    localparam logic [FADE_SHIFT:0] LEVEL_MAX = {1'b1, {FADE_SHIFT{1'b0}}};
    localparam logic [SEL_W-1:0]    RST_SEL   = SEL_W'(RESET_SCENE);

    fade_state_e         state, state_nxt;
    logic [FADE_SHIFT:0] level, level_nxt;
    logic [SEL_W-1:0]    target, target_nxt, cur_nxt;
    logic                zero_now, zero_d, fs, down;
    logic [PIXEL_W-1:0]  src_pixel, dim_pixel;

    // Frame start fires once on entry to 0/0, however long the counters hold there.
    assign zero_now = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign fs       = zero_now && !zero_d;

    always_ff @(posedge clka) begin
        if (rst) begin
            state     <= SHOW;
            level     <= LEVEL_MAX;
            target    <= RST_SEL;
            cur_scene <= RST_SEL;
            zero_d    <= 1'b0;
        end else begin
            state     <= state_nxt;
            level     <= level_nxt;
            target    <= target_nxt;
            cur_scene <= cur_nxt;
            zero_d    <= zero_now;
        end
    end

    always_comb begin
        state_nxt  = state;
        level_nxt  = level;
        target_nxt = target;
        cur_nxt    = cur_scene;
        down       = 1'b0;
        if (fs) begin
            target_nxt = scene_sel;
            case (state)
                SHOW: begin
                    if (scene_sel != cur_scene) begin
                        if (FADE_EN) begin
                            state_nxt = FADE_OUT;
                            down      = 1'b1;
                        end else begin
                            cur_nxt = scene_sel;
                        end
                    end
                end
                FADE_OUT: down = 1'b1;
                FADE_IN: begin
                    if (scene_sel != cur_scene) begin
                        state_nxt = FADE_OUT;
                        down      = 1'b1;
                    end else if (level == LEVEL_MAX - 1'b1) begin
                        level_nxt = LEVEL_MAX;
                        state_nxt = SHOW;
                    end else begin
                        level_nxt = level + 1'b1;
                    end
                end
                default: state_nxt = SHOW;
            endcase
            // Once fading out, the scene swapped in at black is the one latched
            // at the previous frame start, so a late change of mind never aborts.
            if (down) begin
                if (level <= (FADE_SHIFT+1)'(1)) begin
                    level_nxt = '0;
                    cur_nxt   = (state == FADE_OUT) ? target : scene_sel;
                    state_nxt = FADE_IN;
                end else begin
                    level_nxt = level - 1'b1;
                end
            end
        end
    end

    always_comb begin
        fading = (state != SHOW);
    end

    always_comb begin
        src_pixel = BG_COLOR;
        for (int k = 0; k < NUM_SCENES; k++) begin
            if (cur_scene == SEL_W'(k)) src_pixel = scene_pixels[k*PIXEL_W +: PIXEL_W];
        end
    end

    pixel_dimmer #(
        .PIXEL_W    (PIXEL_W),
        .FADE_SHIFT (FADE_SHIFT)
    ) u_dimmer (
        .pixel_in  (src_pixel),
        .level     (level),
        .pixel_out (dim_pixel)
    );

    always_ff @(posedge clka) begin
        if (rst) pixel_out <= '0;
        else     pixel_out <= valid ? dim_pixel : '0;
    end

endmodule

// File: tb/tb_scene_pixel_mux.sv
// Directed bench for scene_pixel_mux: fading instance, hard-cut instance and a
// three-scene instance with an out-of-range background colour.
module tb_scene_pixel_mux;

    logic        clka = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt;
    logic        valid;
    logic [1:0]  sel_f, sel_c, sel_b;
    logic [47:0] pixels;
    logic [11:0] pix_f, pix_c, pix_b;
    logic [1:0]  cur_f, cur_c, cur_b;
    logic        fad_f, fad_c, fad_b;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [11:0] exp_pix;
        logic [1:0]  exp_cur;
        logic        exp_fad;
    } vec_t;

    vec_t fade_tbl[16];

    always #5 clka = ~clka;

    scene_pixel_mux u_fade (
        .clka(clka), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .scene_sel(sel_f), .scene_pixels(pixels),
        .pixel_out(pix_f), .cur_scene(cur_f), .fading(fad_f)
    );

    scene_pixel_mux #(.FADE_EN(1'b0)) u_cut (
        .clka(clka), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .scene_sel(sel_c), .scene_pixels(pixels),
        .pixel_out(pix_c), .cur_scene(cur_c), .fading(fad_c)
    );

    scene_pixel_mux #(.NUM_SCENES(3), .FADE_EN(1'b0), .BG_COLOR(12'h5A3)) u_bg (
        .clka(clka), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .scene_sel(sel_b), .scene_pixels(pixels[35:0]),
        .pixel_out(pix_b), .cur_scene(cur_b), .fading(fad_b)
    );

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    // One frame start followed by one mid-frame cycle, so pixel_out shows the new level.
    task automatic frame();
        h_cnt = 10'd0; v_cnt = 10'd0;
        step();
        h_cnt = 10'd1;
        step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [11:0] dim(input logic [11:0] p, input int l);
        int r, g, b;
        r = (int'(p[11:8]) * l) / 8;
        g = (int'(p[7:4]) * l) / 8;
        b = (int'(p[3:0]) * l) / 8;
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    initial begin
        fade_tbl[0]  = '{2'd2, 12'hDDD, 2'd0, 1'b1};
        fade_tbl[1]  = '{2'd2, 12'hBBB, 2'd0, 1'b1};
        fade_tbl[2]  = '{2'd2, 12'h999, 2'd0, 1'b1};
        fade_tbl[3]  = '{2'd2, 12'h777, 2'd0, 1'b1};
        fade_tbl[4]  = '{2'd2, 12'h555, 2'd0, 1'b1};
        fade_tbl[5]  = '{2'd2, 12'h333, 2'd0, 1'b1};
        fade_tbl[6]  = '{2'd2, 12'h111, 2'd0, 1'b1};
        fade_tbl[7]  = '{2'd2, 12'h000, 2'd2, 1'b1};
        fade_tbl[8]  = '{2'd2, 12'h010, 2'd2, 1'b1};
        fade_tbl[9]  = '{2'd2, 12'h030, 2'd2, 1'b1};
        fade_tbl[10] = '{2'd2, 12'h050, 2'd2, 1'b1};
        fade_tbl[11] = '{2'd2, 12'h070, 2'd2, 1'b1};
        fade_tbl[12] = '{2'd2, 12'h090, 2'd2, 1'b1};
        fade_tbl[13] = '{2'd2, 12'h0B0, 2'd2, 1'b1};
        fade_tbl[14] = '{2'd2, 12'h0D0, 2'd2, 1'b1};
        fade_tbl[15] = '{2'd2, 12'h0F0, 2'd2, 1'b0};

        pixels = {12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
        rst = 1'b1; h_cnt = 10'd1; v_cnt = 10'd1; valid = 1'b1;
        sel_f = 2'd0; sel_c = 2'd0; sel_b = 2'd0;
        step(); step();
        rst = 1'b0;
        check("reset_pix", pix_f, 12'h000);
        check("reset_cur", cur_f, 2'd0);
        check("reset_fading", fad_f, 1'b0);
        step();
        check("first_pix", pix_f, 12'hFFF);

        // Hard cut: selection ignored mid-frame, applied at the frame start.
        sel_c = 2'd1; sel_b = 2'd3;
        step(); step(); step();
        check("cut_midframe_pix", pix_c, 12'hFFF);
        check("cut_midframe_cur", cur_c, 2'd0);
        h_cnt = 10'd0; v_cnt = 10'd0;
        step();
        check("cut_fs_pix", pix_c, 12'hFFF);
        check("cut_fs_cur", cur_c, 2'd1);
        h_cnt = 10'd1;
        step();
        check("cut_new_pix", pix_c, 12'h00F);
        check("cut_fading", fad_c, 1'b0);
        check("bg_cur", cur_b, 2'd3);
        check("bg_pix", pix_b, 12'h5A3);

        valid = 1'b0;
        step();
        check("blank_fade", pix_f, 12'h000);
        check("blank_cut", pix_c, 12'h000);
        check("blank_bg", pix_b, 12'h000);
        valid = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            sel_f = fade_tbl[i].sel;
            frame();
            check($sformatf("fade_pix_%0d", i), pix_f, fade_tbl[i].exp_pix);
            check($sformatf("fade_cur_%0d", i), cur_f, fade_tbl[i].exp_cur);
            check($sformatf("fade_fad_%0d", i), fad_f, fade_tbl[i].exp_fad);
        end
        check("cut_fading_steady", fad_c, 1'b0);

        // Reverse during fade-in: back to scene 0, then switch to scene 1 at level 3.
        sel_f = 2'd0;
        for (int l = 7; l >= 1; l--) begin
            frame();
            check($sformatf("rev_out_%0d", l), pix_f, dim(12'h0F0, l));
        end
        frame();
        check("rev_black_pix", pix_f, 12'h000);
        check("rev_black_cur", cur_f, 2'd0);
        for (int l = 1; l <= 3; l++) begin
            frame();
            check($sformatf("rev_in_%0d", l), pix_f, dim(12'hFFF, l));
        end
        sel_f = 2'd1;
        frame();
        check("rev_turn_pix", pix_f, dim(12'hFFF, 2));
        check("rev_turn_fad", fad_f, 1'b1);
        check("rev_turn_cur", cur_f, 2'd0);
        frame();
        check("rev_l1_pix", pix_f, dim(12'hFFF, 1));
        frame();
        check("rev_l0_pix", pix_f, 12'h000);
        check("rev_l0_cur", cur_f, 2'd1);
        for (int l = 1; l <= 8; l++) begin
            frame();
            check($sformatf("rev_s1_%0d", l), pix_f, dim(12'h00F, l));
        end
        check("rev_done_fad", fad_f, 1'b0);

        // Reset while fading out at level 5.
        sel_f = 2'd2;
        frame(); frame(); frame();
        check("mid_l5_pix", pix_f, dim(12'h00F, 5));
        check("mid_l5_fad", fad_f, 1'b1);
        sel_f = 2'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_pix", pix_f, 12'h000);
        check("rst_mid_cur", cur_f, 2'd0);
        check("rst_mid_fad", fad_f, 1'b0);
        step();
        check("rst_mid_full", pix_f, 12'hFFF);

        // Counters parked at 0/0 for four cycles: only the first is a frame start.
        h_cnt = 10'd0; v_cnt = 10'd0; sel_c = 2'd1;
        step();
        check("hold_first_cur", cur_c, 2'd1);
        sel_c = 2'd2; sel_f = 2'd1;
        step(); step(); step();
        check("hold_cut_cur", cur_c, 2'd1);
        check("hold_fade_fad", fad_f, 1'b0);
        check("hold_fade_cur", cur_f, 2'd0);
        h_cnt = 10'd1;
        step();
        check("hold_cut_pix", pix_c, 12'h00F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
